game_controller: RTL and testbench

//  Top-level whack-a-mole sequencer. Runs the global game FSM (IDLE/LOAD/START/OVER).

---
 rtl/whack_pkg.sv | 20 ++
 rtl/mole_lfsr.sv | 28 ++
 rtl/game_controller.sv | 148 ++++++++++++++
 tb/tb_game_controller.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/whack_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | whack_pkg : shared game-state encoding and LFSR constants                  |
// | Rev 1.0   : initial release                                                |
// +----------------------------------------------------------------------------+
package whack_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    START = 2'd2,
    OVER  = 2'd3
  } game_state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps x^16+x^14+x^13+x^11+1 -> bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage
`default_nettype wire

// File: rtl/mole_lfsr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mole_lfsr : free-running 16-bit Fibonacci LFSR used to pick mole holes     |
// | Rev 1.0   : initial release                                                |
// +----------------------------------------------------------------------------+
module mole_lfsr
  import whack_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] out
);

  logic [15:0] r_lfsr;

  // Nonzero seed keeps the register off the all-zero lockup state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
    end
  end

  assign out = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/game_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | game_controller : whack-a-mole sequencer (game FSM, mole timing, hits)     |
// | Rev 1.0         : initial release                                          |
// +----------------------------------------------------------------------------+
module game_controller
  import whack_pkg::*;
#(
  parameter int N_HOLES        = 4,
  parameter int TICK_DIV       = 50000000,
  parameter int GAME_TICKS     = 30,
  parameter int MOLE_UP_TICKS  = 2,
  parameter int MOLE_GAP_TICKS = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_btn,
  input  logic [N_HOLES-1:0] hit_btn,
  output logic [1:0]         global_state,
  output logic [N_HOLES-1:0] mole_mask,
  output logic               score_clear,
  output logic               score_trigger,
  output logic [7:0]         time_left
);

  localparam int IDX_W   = $clog2(N_HOLES);
  localparam int DIV_W   = $clog2(TICK_DIV);
  localparam int TMR_MAX = (MOLE_UP_TICKS > MOLE_GAP_TICKS) ? MOLE_UP_TICKS : MOLE_GAP_TICKS;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [DIV_W-1:0]   c_DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0]   c_DIV_ONE   = DIV_W'(1);
  localparam logic [TMR_W-1:0]   c_UP_TICKS  = TMR_W'(MOLE_UP_TICKS);
  localparam logic [TMR_W-1:0]   c_GAP_TICKS = TMR_W'(MOLE_GAP_TICKS);
  localparam logic [TMR_W-1:0]   c_TMR_ONE   = TMR_W'(1);
  localparam logic [7:0]         c_GAME      = 8'(GAME_TICKS);
  localparam logic [N_HOLES-1:0] c_HOLE_ONE  = N_HOLES'(1);
  localparam logic [IDX_W-1:0]   c_IDX_ONE   = IDX_W'(1);

  game_state_t        r_state;
  logic [N_HOLES-1:0] r_mask;
  logic               r_score_clear;
  logic               r_score_trig;
  logic [7:0]         r_time;
  logic [DIV_W-1:0]   r_div;
  logic [TMR_W-1:0]   r_timer;
  logic [IDX_W-1:0]   r_prev_idx;

  logic [15:0]        w_lfsr;
  logic [IDX_W-1:0]   w_raw_idx;
  logic [IDX_W-1:0]   w_pick;
  logic [N_HOLES-1:0] w_pick_mask;
  logic               w_tick;
  logic               w_hit;
  logic               w_unused_lfsr;

  mole_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .out   (w_lfsr)
  );

  // Bump to the neighbouring hole so the same hole never shows twice in a row
  assign w_raw_idx     = w_lfsr[IDX_W-1:0];
  assign w_pick        = (w_raw_idx == r_prev_idx) ? w_raw_idx + c_IDX_ONE : w_raw_idx;
  assign w_pick_mask   = c_HOLE_ONE << w_pick;
  assign w_unused_lfsr = ^w_lfsr[15:IDX_W];

  assign w_tick = (r_div == c_DIV_LAST);
  assign w_hit  = |(hit_btn & r_mask);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_mask        <= '0;
      r_score_clear <= 1'b0;
      r_score_trig  <= 1'b0;
      r_time        <= '0;
      r_div         <= '0;
      r_timer       <= '0;
      r_prev_idx    <= '0;
    end else begin
      r_score_clear <= 1'b0;
      r_score_trig  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_btn) begin
            r_state       <= LOAD;
            r_score_clear <= 1'b1;
          end
        end
        LOAD: begin
          r_state    <= START;
          r_time     <= c_GAME;
          r_div      <= '0;
          r_mask     <= w_pick_mask;
          r_prev_idx <= w_pick;
          r_timer    <= c_UP_TICKS;
        end
        START: begin
          r_div <= w_tick ? '0 : r_div + c_DIV_ONE;
          if (w_tick && (r_time != '0)) begin
            r_time <= r_time - 8'd1;
          end
          // Final tick ends the game; a hit landing on it still scores
          if (w_tick && (r_time == 8'd1)) begin
            r_state      <= OVER;
            r_mask       <= '0;
            r_score_trig <= w_hit;
          end else if (w_hit) begin
            r_score_trig <= 1'b1;
            r_mask       <= '0;
            r_timer      <= c_GAP_TICKS;
          end else if (w_tick) begin
            if (r_timer <= c_TMR_ONE) begin
              if (|r_mask) begin
                r_mask  <= '0;
                r_timer <= c_GAP_TICKS;
              end else begin
                r_mask     <= w_pick_mask;
                r_prev_idx <= w_pick;
                r_timer    <= c_UP_TICKS;
              end
            end else begin
              r_timer <= r_timer - c_TMR_ONE;
            end
          end
        end
        OVER: begin
          r_mask <= '0;
          if (start_btn) begin
            r_state       <= LOAD;
            r_score_clear <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign global_state  = r_state;
  assign mole_mask     = r_mask;
  assign score_clear   = r_score_clear;
  assign score_trigger = r_score_trig;
  assign time_left     = r_time;

endmodule
`default_nettype wire

// File: tb/tb_game_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_game_controller : directed bench with a tick-count reference model      |
// | Rev 1.0            : initial release                                       |
// +----------------------------------------------------------------------------+
module tb_game_controller;

  localparam int N_HOLES        = 4;
  localparam int TICK_DIV       = 4;
  localparam int GAME_TICKS     = 10;
  localparam int MOLE_UP_TICKS  = 2;
  localparam int MOLE_GAP_TICKS = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_btn;
  logic [3:0] hit_btn;
  logic [1:0] global_state;
  logic [3:0] mole_mask;
  logic       score_clear;
  logic       score_trigger;
  logic [7:0] time_left;

  int total = 0;
  int bad   = 0;

  game_controller #(
    .N_HOLES        (N_HOLES),
    .TICK_DIV       (TICK_DIV),
    .GAME_TICKS     (GAME_TICKS),
    .MOLE_UP_TICKS  (MOLE_UP_TICKS),
    .MOLE_GAP_TICKS (MOLE_GAP_TICKS)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_btn     (start_btn),
    .hit_btn       (hit_btn),
    .global_state  (global_state),
    .mole_mask     (mole_mask),
    .score_clear   (score_clear),
    .score_trigger (score_trigger),
    .time_left     (time_left)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: game time kept as elapsed START cycles, mole phases as absolute tick deadlines
  int          m_phase;
  int          m_ncyc;
  int          m_seg_end;
  int          m_hole;
  int          m_prev;
  bit          m_clear;
  bit          m_trig;
  bit          m_valid = 1'b0;
  logic [15:0] m_lfsr;
  int          mv_raw;
  int          mv_pick;
  int          mv_ticks;
  bit          mv_tick;
  bit          mv_hit;

  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      m_phase = 0; m_ncyc = 0; m_seg_end = 0; m_hole = -1; m_prev = 0;
      m_clear = 0; m_trig = 0; m_lfsr = 16'hACE1; m_valid = 1'b1;
    end else if (m_valid) begin
      mv_raw  = int'(m_lfsr[1:0]);
      mv_pick = (mv_raw == m_prev) ? (mv_raw + 1) % N_HOLES : mv_raw;
      m_clear = 0;
      m_trig  = 0;
      case (m_phase)
        0, 3: begin
          m_hole = -1;
          if (start_btn) begin m_phase = 1; m_clear = 1; end
        end
        1: begin
          m_phase = 2; m_ncyc = 0; m_hole = mv_pick; m_prev = mv_pick;
          m_seg_end = MOLE_UP_TICKS;
        end
        default: begin
          mv_tick  = ((m_ncyc % TICK_DIV) == TICK_DIV - 1);
          mv_ticks = (m_ncyc + 1) / TICK_DIV;
          mv_hit   = (m_hole >= 0) && hit_btn[m_hole];
          m_ncyc++;
          if (mv_tick && mv_ticks == GAME_TICKS) begin
            m_phase = 3; m_hole = -1; m_trig = mv_hit;
          end else if (mv_hit) begin
            m_trig = 1; m_hole = -1; m_seg_end = mv_ticks + MOLE_GAP_TICKS;
          end else if (mv_tick && mv_ticks == m_seg_end) begin
            if (m_hole >= 0) begin
              m_hole = -1; m_seg_end = m_seg_end + MOLE_GAP_TICKS;
            end else begin
              m_hole = mv_pick; m_prev = mv_pick; m_seg_end = m_seg_end + MOLE_UP_TICKS;
            end
          end
        end
      endcase
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("model_state", 32'(global_state), 32'(m_phase));
      chk("model_mask", 32'(mole_mask), (m_hole >= 0) ? 32'(1 << m_hole) : 32'd0);
      chk("model_time", 32'(time_left), (m_phase == 2) ? 32'(GAME_TICKS - m_ncyc / TICK_DIV) : 32'd0);
      chk("model_clear", 32'(score_clear), 32'(m_clear));
      chk("model_trig", 32'(score_trigger), 32'(m_trig));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [3:0] prev_mask;
  logic [3:0] cur_mask;
  int         waited;
  bit         found;

  initial begin
    rst_n = 1'b0; start_btn = 1'b0; hit_btn = 4'h0;
    @(negedge clk); @(negedge clk);
    chk("rst_state", 32'(global_state), 0);
    chk("rst_mask", 32'(mole_mask), 0);
    chk("rst_time", 32'(time_left), 0);
    chk("rst_clear", 32'(score_clear), 0);
    chk("rst_trig", 32'(score_trigger), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Game A: load, correct hit, gap length, wrong and multi-bit hits
    start_btn = 1'b1; @(negedge clk); start_btn = 1'b0;
    chk("load_state", 32'(global_state), 1);
    chk("load_clear", 32'(score_clear), 1);
    @(negedge clk);
    chk("start_state", 32'(global_state), 2);
    chk("start_time", 32'(time_left), 10);
    chk("start_onehot", 32'($countones(mole_mask)), 1);
    chk("start_clear_off", 32'(score_clear), 0);
    prev_mask = mole_mask;
    hit_btn = mole_mask; @(negedge clk); hit_btn = 4'h0;
    chk("hit_trig", 32'(score_trigger), 1);
    chk("hit_mask", 32'(mole_mask), 0);
    hit_btn = 4'hF; @(negedge clk); hit_btn = 4'h0;
    chk("trig_single_and_empty_hit", 32'(score_trigger), 0);
    found = 1'b0; waited = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (mole_mask != 4'h0) found = 1'b1;
      else begin @(negedge clk); waited++; end
    end
    chk("new_mole_seen", 32'(found), 1);
    chk("gap_len", 32'(waited), 2);
    chk("new_mole_differs", 32'(mole_mask != prev_mask), 1);
    cur_mask = mole_mask;
    hit_btn = {cur_mask[2:0], cur_mask[3]}; @(negedge clk); hit_btn = 4'h0;
    chk("wrong_hole_trig", 32'(score_trigger), 0);
    chk("wrong_hole_mask", 32'(mole_mask), 32'(cur_mask));
    hit_btn = 4'hF; @(negedge clk); hit_btn = 4'h0;
    chk("all_bits_trig", 32'(score_trigger), 1);
    @(negedge clk);
    chk("all_bits_one_pulse", 32'(score_trigger), 0);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (global_state == 2'd3) found = 1'b1;
      else @(negedge clk);
    end
    chk("game_a_over", 32'(found), 1);
    chk("over_time", 32'(time_left), 0);
    chk("over_mask", 32'(mole_mask), 0);
    hit_btn = 4'hF; @(negedge clk); hit_btn = 4'h0;
    chk("over_hit_ignored", 32'(score_trigger), 0);

    // Game B: untouched cadence, then a hit on the final tick
    start_btn = 1'b1; @(negedge clk); start_btn = 1'b0;
    chk("restart_load", 32'(global_state), 1);
    chk("restart_clear", 32'(score_clear), 1);
    @(negedge clk);
    for (int i = 1; i <= 40; i++) begin
      if (i == 8)  chk("mole_up_c8", 32'(mole_mask != 4'h0), 1);
      if (i == 9)  chk("mole_down_c9", 32'(mole_mask), 0);
      if (i == 12) chk("mole_down_c12", 32'(mole_mask), 0);
      if (i == 13) chk("mole_up_c13", 32'(mole_mask != 4'h0), 1);
      if (i == 40) begin
        chk("final_cycle_state", 32'(global_state), 2);
        chk("final_cycle_time", 32'(time_left), 1);
        hit_btn = mole_mask;
      end
      @(negedge clk);
    end
    hit_btn = 4'h0;
    chk("final_hit_state", 32'(global_state), 3);
    chk("final_hit_trig", 32'(score_trigger), 1);
    chk("final_hit_time", 32'(time_left), 0);
    chk("final_hit_mask", 32'(mole_mask), 0);

    // Game C: start ignored mid-game, then mid-game reset
    start_btn = 1'b1; @(negedge clk); start_btn = 1'b0;
    chk("game_c_clear", 32'(score_clear), 1);
    @(negedge clk);
    chk("game_c_time", 32'(time_left), 10);
    for (int i = 0; i < 4; i++) @(negedge clk);
    chk("game_c_tick", 32'(time_left), 9);
    start_btn = 1'b1; @(negedge clk); start_btn = 1'b0;
    chk("start_ignored_state", 32'(global_state), 2);
    chk("start_ignored_time", 32'(time_left), 9);
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    chk("midreset_state", 32'(global_state), 0);
    chk("midreset_mask", 32'(mole_mask), 0);
    chk("midreset_time", 32'(time_left), 0);
    chk("midreset_trig", 32'(score_trigger), 0);
    @(negedge clk); @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
